// File: rtl/alu_issue_ctrl.sv
// Execute-stage sequencer in front of the registered 16-bit ALU: latches one request,
// drives the ALU for the cycles its result and delayed zero flag need, and returns the response.
module alu_issue_ctrl #(
   parameter int DATA_W = 16,
   parameter int OP_W   = 3,
   parameter int CNT_W  = 16
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_req_valid,
   output logic              o_req_ready,
   input  logic [DATA_W-1:0] i_req_a,
   input  logic [DATA_W-1:0] i_req_b,
   input  logic [OP_W-1:0]   i_req_op,
   output logic [DATA_W-1:0] o_alu_in1,
   output logic [DATA_W-1:0] o_alu_in2,
   output logic [OP_W-1:0]   o_alu_op,
   input  logic [DATA_W-1:0] i_alu_out,
   input  logic              i_alu_z,
   output logic              o_resp_valid,
   input  logic              i_resp_ready,
   output logic [DATA_W-1:0] o_resp_data,
   output logic              o_resp_zero,
   output logic              o_resp_err,
   output logic [CNT_W-1:0]  o_op_count
);

   localparam logic [OP_W-1:0] OP_NOP = OP_W'(0);
   localparam logic [OP_W-1:0] OP_ADD = OP_W'(1);
   localparam logic [OP_W-1:0] OP_SUB = OP_W'(2);
   localparam logic [OP_W-1:0] OP_MUL = OP_W'(3);
   localparam logic [OP_W-1:0] OP_DIV = OP_W'(4);
   localparam logic [OP_W-1:0] OP_MOD = OP_W'(5);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      EXEC = 3'd1,
      WAIT = 3'd2,
      CAPT = 3'd3,
      RESP = 3'd4
   } state_t;

   state_t state_r;
   logic   req_err_s;

   // Screen illegal opcodes and zero divisors so they never reach the ALU.
   always_comb begin
      req_err_s = 1'b0;
      case (i_req_op)
         OP_ADD, OP_SUB, OP_MUL: req_err_s = 1'b0;
         OP_DIV, OP_MOD:         req_err_s = (i_req_a == {DATA_W{1'b0}});
         default:                req_err_s = 1'b1;
      endcase
   end

   // Sequencer: state, ALU drive, response capture and completion counter.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_r      <= IDLE;
         o_req_ready  <= 1'b0;
         o_alu_in1    <= {DATA_W{1'b0}};
         o_alu_in2    <= {DATA_W{1'b0}};
         o_alu_op     <= OP_NOP;
         o_resp_valid <= 1'b0;
         o_resp_data  <= {DATA_W{1'b0}};
         o_resp_zero  <= 1'b0;
         o_resp_err   <= 1'b0;
         o_op_count   <= {CNT_W{1'b0}};
      end else begin
         case (state_r)
            IDLE: begin
               o_req_ready <= 1'b1;
               o_alu_op    <= OP_NOP;
               if (i_req_valid && o_req_ready) begin
                  o_req_ready <= 1'b0;
                  if (req_err_s) begin
                     state_r      <= RESP;
                     o_resp_valid <= 1'b1;
                     o_resp_data  <= {DATA_W{1'b0}};
                     o_resp_zero  <= 1'b1;
                     o_resp_err   <= 1'b1;
                  end else begin
                     state_r   <= EXEC;
                     o_alu_in1 <= i_req_a;
                     o_alu_in2 <= i_req_b;
                     o_alu_op  <= i_req_op;
                  end
               end
            end
            EXEC: state_r <= WAIT;
            WAIT: state_r <= CAPT;
            // Result was registered at the end of EXEC, its zero flag at the end of WAIT.
            CAPT: begin
               state_r      <= RESP;
               o_alu_op     <= OP_NOP;
               o_resp_valid <= 1'b1;
               o_resp_data  <= i_alu_out;
               o_resp_zero  <= i_alu_z;
               o_resp_err   <= 1'b0;
            end
            RESP: begin
               if (i_resp_ready) begin
                  state_r      <= IDLE;
                  o_resp_valid <= 1'b0;
                  o_req_ready  <= 1'b1;
                  o_op_count   <= o_op_count + CNT_W'(1);
               end
            end
            default: begin
               state_r      <= IDLE;
               o_req_ready  <= 1'b0;
               o_alu_op     <= OP_NOP;
               o_resp_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Scoreboard bench for alu_issue_ctrl with a behavioural registered ALU attached.
module tb_alu_issue_ctrl;

   localparam int DATA_W = 16;
   localparam int OP_W   = 3;
   // Narrow counter so wraparound is reachable in a short run.
   localparam int CNT_W  = 6;
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   typedef logic [DATA_W+1:0] resp_t;  // {err, zero, data}

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              req_valid = 1'b0;
   logic              req_ready;
   logic [DATA_W-1:0] req_a = 16'h0000;
   logic [DATA_W-1:0] req_b = 16'h0000;
   logic [OP_W-1:0]   req_op = 3'd0;
   logic [DATA_W-1:0] alu_in1, alu_in2;
   logic [OP_W-1:0]   alu_op;
   logic [DATA_W-1:0] alu_out;
   logic              alu_z;
   logic              resp_valid;
   logic              resp_ready = 1'b1;
   logic [DATA_W-1:0] resp_data;
   logic              resp_zero, resp_err;
   logic [CNT_W-1:0]  op_count;

   int          n_vec = 0;
   int          n_err = 0;
   resp_t       exp_q[$];
   logic [CNT_W-1:0] exp_cnt = {CNT_W{1'b0}};

   always #5 clk = ~clk;

   alu_issue_ctrl #(.DATA_W(DATA_W), .OP_W(OP_W), .CNT_W(CNT_W)) dut (
      .i_clk(clk), .i_rst(rst),
      .i_req_valid(req_valid), .o_req_ready(req_ready),
      .i_req_a(req_a), .i_req_b(req_b), .i_req_op(req_op),
      .o_alu_in1(alu_in1), .o_alu_in2(alu_in2), .o_alu_op(alu_op),
      .i_alu_out(alu_out), .i_alu_z(alu_z),
      .o_resp_valid(resp_valid), .i_resp_ready(resp_ready),
      .o_resp_data(resp_data), .o_resp_zero(resp_zero), .o_resp_err(resp_err),
      .o_op_count(op_count)
   );

   function automatic logic [DATA_W-1:0] alu_f(input logic [DATA_W-1:0] a, b, input logic [OP_W-1:0] op);
      logic [2*DATA_W-1:0] p;
      p = 32'h0;
      case (op)
         3'd1: alu_f = a + b;
         3'd2: alu_f = (b > a) ? (b - a) : 16'h0000;
         3'd3: begin p = a * b; alu_f = p[DATA_W-1:0]; end
         3'd4: alu_f = (a != 16'h0000) ? (b / a) : 16'hFFFF;
         3'd5: alu_f = (a != 16'h0000) ? (b % a) : 16'hFFFF;
         default: alu_f = 16'h0000;
      endcase
   endfunction

   // Registered ALU: result one cycle after its inputs, zero flag one cycle after that.
   always @(posedge clk) begin
      if (alu_op != 3'd0) begin
         alu_out <= alu_f(alu_in1, alu_in2, alu_op);
         alu_z   <= (alu_out == 16'h0000);
      end
   end

   function automatic resp_t ref_resp(input logic [DATA_W-1:0] a, b, input logic [OP_W-1:0] op);
      logic [DATA_W-1:0] r;
      if (op == 3'd0 || op > 3'd5 || ((op == 3'd4 || op == 3'd5) && a == 16'h0000)) begin
         ref_resp = {1'b1, 1'b1, 16'h0000};
      end else begin
         r = alu_f(a, b, op);
         ref_resp = {1'b0, (r == 16'h0000), r};
      end
   endfunction

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic run_op(input logic [DATA_W-1:0] a, b, input logic [OP_W-1:0] op, input int bp);
      resp_t e;
      logic  is_err;
      int    lat;
      int    w;
      @(negedge clk);
      req_valid = 1'b1; req_a = a; req_b = b; req_op = op;
      resp_ready = (bp == 0);
      w = 0;
      while (!req_ready && w < 20) begin
         @(negedge clk);
         w++;
      end
      check_eq("req_ready", {31'b0, req_ready}, 32'd1);
      e = ref_resp(a, b, op);
      is_err = e[DATA_W+1];
      exp_q.push_back(e);
      @(posedge clk);
      lat = 0;
      while (!resp_valid && lat < 10) begin
         @(negedge clk);
         lat++;
         req_valid = 1'b0;
         if (!resp_valid) check_eq("alu_op", {29'b0, alu_op}, is_err ? 32'd0 : {29'b0, op});
         if (lat == 1 && !is_err) begin
            check_eq("alu_in1", {16'b0, alu_in1}, {16'b0, a});
            check_eq("alu_in2", {16'b0, alu_in2}, {16'b0, b});
         end
      end
      check_eq("latency", lat, is_err ? 32'd1 : 32'd4);
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check_eq("resp", {14'b0, resp_err, resp_zero, resp_data}, {14'b0, e});
      end else begin
         check_eq("sb_empty", 32'd1, 32'd0);
      end
      check_eq("resp_alu_op", {29'b0, alu_op}, 32'd0);
      if (bp > 0) begin
         req_valid = 1'b1; req_a = ~a; req_b = b; req_op = 3'd1;
         for (int i = 0; i < bp; i++) begin
            @(negedge clk);
            check_eq("bp_resp", {14'b0, resp_err, resp_zero, resp_data}, {14'b0, e});
            check_eq("bp_valid", {31'b0, resp_valid}, 32'd1);
            check_eq("bp_ready", {31'b0, req_ready}, 32'd0);
            check_eq("bp_alu_op", {29'b0, alu_op}, 32'd0);
         end
         req_valid = 1'b0;
         resp_ready = 1'b1;
      end
      @(posedge clk);
      exp_cnt = exp_cnt + 6'd1;
      @(negedge clk);
      check_eq("post_valid", {31'b0, resp_valid}, 32'd0);
      check_eq("count", {26'b0, op_count}, {26'b0, exp_cnt});
      check_eq("idle_ready", {31'b0, req_ready}, 32'd1);
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check_eq("rst_valid", {31'b0, resp_valid}, 32'd0);
      check_eq("rst_alu_op", {29'b0, alu_op}, 32'd0);
      check_eq("rst_count", {26'b0, op_count}, 32'd0);
      check_eq("rst_ready", {31'b0, req_ready}, 32'd0);
      exp_q.delete();
      exp_cnt = {CNT_W{1'b0}};
      rst = 1'b0;
      @(negedge clk);
      check_eq("rel_ready", {31'b0, req_ready}, 32'd1);
   endtask

   initial begin
      #1000000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1);
   end

   initial begin
      repeat (3) @(negedge clk);
      check_eq("rst_valid", {31'b0, resp_valid}, 32'd0);
      check_eq("rst_count", {26'b0, op_count}, 32'd0);
      check_eq("rst_alu_op", {29'b0, alu_op}, 32'd0);
      check_eq("rst_in1", {16'b0, alu_in1}, 32'd0);
      check_eq("rst_ready", {31'b0, req_ready}, 32'd0);
      rst = 1'b0;
      @(negedge clk);
      check_eq("rel_ready", {31'b0, req_ready}, 32'd1);

      run_op(16'd3, 16'd4, 3'd1, 0);
      run_op(16'd9, 16'd5, 3'd2, 0);
      run_op(16'd5, 16'd9, 3'd2, 0);
      run_op(16'd0, 16'd10, 3'd4, 0);
      run_op(16'd0, 16'd10, 3'd5, 0);
      run_op(16'd1, 16'd2, 3'd6, 0);
      run_op(16'd7, 16'd50, 3'd5, 0);
      run_op(16'h0100, 16'h0100, 3'd3, 0);
      run_op(16'd3, 16'd100, 3'd4, 0);
      run_op(16'd1, 16'd1, 3'd0, 0);
      run_op(16'd1, 16'd1, 3'd7, 0);
      run_op(16'h1234, 16'h5678, 3'd1, 6);
      run_op(16'd0, 16'd5, 3'd4, 3);

      // Reset while the ALU is mid-operation (state WAIT).
      @(negedge clk);
      req_valid = 1'b1; req_a = 16'd3; req_b = 16'd4; req_op = 3'd1; resp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check_eq("wait_alu_op", {29'b0, alu_op}, 32'd1);
      apply_reset();
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check_eq("no_stale_resp", {31'b0, resp_valid}, 32'd0);
      end

      while (exp_cnt != CNT_MAX) run_op(16'd0, 16'd0, 3'd0, 0);
      check_eq("at_max", {26'b0, op_count}, {26'b0, CNT_MAX});
      apply_reset();
      while (exp_cnt != CNT_MAX) run_op(16'd0, 16'd0, 3'd0, 0);
      run_op(16'd2, 16'd2, 3'd1, 0);
      check_eq("wrap", {26'b0, op_count}, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
